// File: rtl/mem_portb_arbiter_if.sv
// Port-b arbitration bus: two requester channels plus the shared Memory port b.
// err1 exists only when MEM_ARB_IO_GUARD_EN is defined.
interface mem_portb_arbiter_if;
  logic        req0;
  logic        we0;
  logic [31:0] addr0;
  logic [31:0] wdata0;
  logic        lock0;
  logic        gnt0;
  logic        rvalid0;
  logic [31:0] rdata0;

  logic        req1;
  logic        we1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        lock1;
  logic        gnt1;
  logic        rvalid1;
  logic [31:0] rdata1;

  logic [31:0] addrb;
  logic [31:0] write_datab;
  logic        web;
  logic [31:0] datab;
`ifdef MEM_ARB_IO_GUARD_EN
  logic        err1;
`endif

  modport slave (
    input  req0, we0, addr0, wdata0, lock0,
    output gnt0, rvalid0, rdata0,
    input  req1, we1, addr1, wdata1, lock1,
    output gnt1, rvalid1, rdata1,
    output addrb, write_datab, web,
    input  datab
`ifdef MEM_ARB_IO_GUARD_EN
    , output err1
`endif
  );

  modport master (
    output req0, we0, addr0, wdata0, lock0,
    input  gnt0, rvalid0, rdata0,
    output req1, we1, addr1, wdata1, lock1,
    input  gnt1, rvalid1, rdata1,
    input  addrb, write_datab, web,
    output datab
`ifdef MEM_ARB_IO_GUARD_EN
    , input err1
`endif
  );
endinterface

// File: rtl/mem_portb_arbiter.sv
// Round-robin arbiter for Memory port b with bounded burst locking.
// Define MEM_ARB_IO_GUARD_EN to block requester-1 accesses to IO space (except VGA windows).
module mem_portb_arbiter #(
  parameter int unsigned MAX_LOCK  = 16,
  parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst_n,
  mem_portb_arbiter_if.slave bus
);

  // state | meaning
  // IDLE  | no lock held, plain round-robin
  // OWN0  | CPU holds a lock
  // OWN1  | requester 1 holds a lock
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [7:0] LOCK_LAST = 8'(MAX_LOCK - 1);

  state_e      state_q, state_d;
  logic        last_gnt_q;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        rvalid0_q, rvalid1_q;
  logic [31:0] rdata0_q, rdata1_q;
  logic        gnt0, gnt1, blocked1, other_wait;
  logic [31:0] addrb_c, wdatab_c;
  logic        web_c;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (state_q == OWN0 && bus.req0) begin
        if (bus.req1 && lock_cnt_q == LOCK_LAST) gnt1 = 1'b1;
        else                                     gnt0 = 1'b1;
      end else if (state_q == OWN1 && bus.req1) begin
        if (bus.req0 && lock_cnt_q == LOCK_LAST) gnt0 = 1'b1;
        else                                     gnt1 = 1'b1;
      end else if (bus.req0 && bus.req1) begin
        gnt0 = last_gnt_q;
        gnt1 = ~last_gnt_q;
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
    end
  end

`ifdef MEM_ARB_IO_GUARD_EN
  // VGA text/attribute windows live inside IO space but stay reachable by the DMA.
  assign blocked1 = gnt1 && (bus.addr1[31:16] == 16'hffff) &&
                    (bus.addr1[31:12] != 20'hffffe) && (bus.addr1[31:12] != 20'hffffd);
`else
  assign blocked1 = 1'b0;
`endif

  always_comb begin
    addrb_c  = IDLE_ADDR;
    wdatab_c = 32'h0;
    web_c    = 1'b0;
    if (gnt0) begin
      addrb_c  = bus.addr0;
      wdatab_c = bus.wdata0;
      web_c    = bus.we0;
    end else if (gnt1 && !blocked1) begin
      addrb_c  = bus.addr1;
      wdatab_c = bus.wdata1;
      web_c    = bus.we1;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (gnt0 && bus.lock0)      state_d = OWN0;
    else if (gnt1 && bus.lock1) state_d = OWN1;

    other_wait = (state_q == OWN0) ? bus.req1 : bus.req0;
    lock_cnt_d = 8'd0;
    if (state_d != IDLE && state_d == state_q)
      lock_cnt_d = other_wait ? lock_cnt_q + 8'd1 : lock_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      lock_cnt_q <= 8'd0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= 32'h0;
      rdata1_q   <= 32'h0;
`ifdef MEM_ARB_IO_GUARD_EN
      bus.err1   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      if (gnt0 || gnt1) last_gnt_q <= gnt1;
      rvalid0_q  <= gnt0 && !bus.we0;
      rvalid1_q  <= gnt1 && !bus.we1;
      if (gnt0 && !bus.we0) rdata0_q <= bus.datab;
      if (gnt1 && !bus.we1) rdata1_q <= blocked1 ? 32'h0 : bus.datab;
`ifdef MEM_ARB_IO_GUARD_EN
      bus.err1   <= blocked1;
`endif
    end
  end

  assign bus.gnt0        = gnt0;
  assign bus.gnt1        = gnt1;
  assign bus.rvalid0     = rvalid0_q;
  assign bus.rvalid1     = rvalid1_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;
  assign bus.addrb       = addrb_c;
  assign bus.write_datab = wdatab_c;
  assign bus.web         = web_c;

endmodule

// File: tb/tb_mem_portb_arbiter.sv
// Bench for mem_portb_arbiter: directed plan steps, then constrained-random traffic vs a reference model.
module tb_mem_portb_arbiter;
  localparam int MAXL = 4;
`ifdef MEM_ARB_IO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_portb_arbiter_if bus();

  mem_portb_arbiter #(.MAX_LOCK(MAXL), .IDLE_ADDR(32'h0000_0000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: owner (-1 none), last winner, hold streak, pending read returns
  int          m_owner, m_last, m_streak;
  logic        m_rv[2];
  logic [31:0] m_rd[2];
  logic        m_err;

  int          last_win;
  logic        obs_gnt0, obs_gnt1, obs_web;
  logic [31:0] obs_addrb, obs_wdb;
  logic        pend[2];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_blocked(int win, logic [31:0] a);
    return GUARD && win == 1 && a[31:16] == 16'hffff &&
           a[31:12] != 20'hffffe && a[31:12] != 20'hffffd;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_last   = 1;
    m_streak = 0;
    m_rv[0]  = 1'b0;
    m_rv[1]  = 1'b0;
    m_rd[0]  = 32'h0;
    m_rd[1]  = 32'h0;
    m_err    = 1'b0;
  endtask

  task automatic drive(int i, logic r, logic w, logic [31:0] a, logic [31:0] d, logic l);
    if (i == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; bus.lock0 = l;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; bus.lock1 = l;
    end
  endtask

  task automatic step();
    logic        rq[2], lk[2], we[2];
    logic [31:0] ad[2], wd[2];
    logic [31:0] e_addr, e_wd, db;
    logic        e_we, blk, rst_now;
    int          win, nown;
    @(negedge clk);
    rq[0] = bus.req0;  rq[1] = bus.req1;
    lk[0] = bus.lock0; lk[1] = bus.lock1;
    we[0] = bus.we0;   we[1] = bus.we1;
    ad[0] = bus.addr0; ad[1] = bus.addr1;
    wd[0] = bus.wdata0; wd[1] = bus.wdata1;
    db = bus.datab;
    rst_now = rst_n;
    win = -1;
    if (rst_now) begin
      if (m_owner >= 0 && rq[m_owner])
        win = (rq[1-m_owner] && m_streak == MAXL-1) ? 1 - m_owner : m_owner;
      else if (rq[0] && rq[1]) win = 1 - m_last;
      else if (rq[0])          win = 0;
      else if (rq[1])          win = 1;
    end
    blk = is_blocked(win, ad[1]);
    e_addr = 32'h0; e_wd = 32'h0; e_we = 1'b0;
    if (win >= 0 && !blk) begin
      e_addr = ad[win]; e_wd = wd[win]; e_we = we[win];
    end
    obs_gnt0 = bus.gnt0; obs_gnt1 = bus.gnt1; obs_web = bus.web;
    obs_addrb = bus.addrb; obs_wdb = bus.write_datab;
    check("gnt0", {31'h0, obs_gnt0}, {31'h0, win == 0});
    check("gnt1", {31'h0, obs_gnt1}, {31'h0, win == 1});
    check("web", {31'h0, obs_web}, {31'h0, e_we});
    check("addrb", obs_addrb, e_addr);
    check("write_datab", obs_wdb, e_wd);
    check("rvalid0", {31'h0, bus.rvalid0}, {31'h0, m_rv[0]});
    check("rvalid1", {31'h0, bus.rvalid1}, {31'h0, m_rv[1]});
    check("rdata0", bus.rdata0, m_rd[0]);
    check("rdata1", bus.rdata1, m_rd[1]);
`ifdef MEM_ARB_IO_GUARD_EN
    check("err1", {31'h0, bus.err1}, {31'h0, m_err});
`endif
    last_win = win;
    @(posedge clk);
    if (!rst_now) begin
      model_reset();
    end else begin
      nown = (win >= 0 && lk[win]) ? win : -1;
      if (nown >= 0 && nown == m_owner) begin
        if (rq[1-m_owner]) m_streak++;
      end else begin
        m_streak = 0;
      end
      m_owner = nown;
      if (win >= 0) m_last = win;
      m_rv[0] = (win == 0) && !we[0];
      m_rv[1] = (win == 1) && !we[1];
      if (m_rv[0]) m_rd[0] = db;
      if (m_rv[1]) m_rd[1] = blk ? 32'h0 : db;
      m_err = blk;
    end
    #1;
  endtask

  function automatic logic [31:0] rand_addr(int i);
    logic [31:0] r;
    r = $urandom();
    if (i == 1) begin
      case ($urandom_range(0, 3))
        0: r = {16'hffff, r[15:0]};
        1: r = {20'hffffe, r[11:0]};
        2: r = {20'hffffd, r[11:0]};
        default: ;
      endcase
    end
    return r;
  endfunction

  initial begin
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    bus.datab = 32'h0;
    last_win = -1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;

    // reset state, with a request present to show grants are suppressed
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    drive(0, 1'b1, 1'b1, 32'h0000_0044, 32'h55, 1'b0);
    @(negedge clk);
    check("rst_gnt0", {31'h0, bus.gnt0}, 32'h0);
    check("rst_web", {31'h0, bus.web}, 32'h0);
    check("rst_addrb", bus.addrb, 32'h0);
    check("rst_wdb", bus.write_datab, 32'h0);
    check("rst_rvalid0", {31'h0, bus.rvalid0}, 32'h0);
    check("rst_rdata1", bus.rdata1, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single CPU read
    drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    bus.datab = 32'hDEAD_BEEF;
    step();
    check("t1_gnt0", {31'h0, obs_gnt0}, 32'h1);
    check("t1_addrb", obs_addrb, 32'h0000_0010);
    check("t1_rvalid0", {31'h0, bus.rvalid0}, 32'h1);
    check("t1_rdata0", bus.rdata0, 32'hDEAD_BEEF);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    bus.datab = 32'h1234_5678;
    step();
    check("t1_rvalid_pulse", {31'h0, bus.rvalid0}, 32'h0);
    check("t1_rdata_hold", bus.rdata0, 32'hDEAD_BEEF);

    // both requesting, no lock: strict alternation (CPU won last, so 1 first)
    drive(0, 1'b1, 1'b1, 32'h0000_0020, 32'h11, 1'b0);
    drive(1, 1'b1, 1'b0, 32'h0000_0030, 32'h22, 1'b0);
    for (int k = 0; k < 4; k++) begin
      bus.datab = 32'hA000_0000 + k;
      step();
      check("t2_gnt1", {31'h0, obs_gnt1}, {31'h0, k % 2 == 0});
      check("t2_web", {31'h0, obs_web}, {31'h0, k % 2 == 1});
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();

    // requester 1 locks, CPU waits: 3 more grants to 1, forced release, then round-robin
    drive(1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b1);
    step();
    check("t3_own", {31'h0, obs_gnt1}, 32'h1);
    drive(0, 1'b1, 1'b0, 32'h0000_0050, 32'h0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t3_gnt0", {31'h0, obs_gnt0}, {31'h0, k == 3});
      check("t3_gnt1", {31'h0, obs_gnt1}, {31'h0, k != 3});
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    step();

    // VGA write passes through regardless of guard
    drive(1, 1'b1, 1'b1, 32'hFFFF_E005, 32'h41, 1'b0);
    step();
    check("t4_web", {31'h0, obs_web}, 32'h1);
    check("t4_addrb", obs_addrb, 32'hFFFF_E005);
    check("t4_wdb", obs_wdb, 32'h41);
    check("t4_rvalid1", {31'h0, bus.rvalid1}, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();

`ifdef MEM_ARB_IO_GUARD_EN
    drive(1, 1'b1, 1'b1, 32'hFFFF_FF0C, 32'h99, 1'b0);
    step();
    check("t5_gnt1", {31'h0, obs_gnt1}, 32'h1);
    check("t5_web", {31'h0, obs_web}, 32'h0);
    check("t5_addrb", obs_addrb, 32'h0);
    check("t5_err1", {31'h0, bus.err1}, 32'h1);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
`endif

    // reset while CPU holds a lock with a read in flight
    drive(0, 1'b1, 1'b0, 32'h0000_0060, 32'h0, 1'b1);
    bus.datab = 32'hCAFE_0001;
    step();
    check("t6_gnt0", {31'h0, obs_gnt0}, 32'h1);
    rst_n = 1'b0;
    step();
    check("t6_rvalid0", {31'h0, bus.rvalid0}, 32'h0);
    rst_n = 1'b1;
    drive(1, 1'b1, 1'b0, 32'h0000_0070, 32'h0, 1'b0);
    step();
    check("t6_tie_gnt0", {31'h0, obs_gnt0}, 32'h1);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();

    // random traffic honouring the hold-until-granted protocol
    last_win = -1;
    for (int c = 0; c < 3000; c++) begin
      bus.datab = $urandom();
      for (int i = 0; i < 2; i++) begin
        if (last_win == i) pend[i] = 1'b0;
        if (!pend[i]) begin
          if ($urandom_range(0, 99) < 55) begin
            pend[i] = 1'b1;
            drive(i, 1'b1, 1'($urandom_range(0, 1)), rand_addr(i), $urandom(), 1'b0);
          end else begin
            drive(i, 1'b0, 1'b0, rand_addr(i), $urandom(), 1'b0);
          end
        end
      end
      bus.lock0 = ($urandom_range(0, 99) < 40);
      bus.lock1 = ($urandom_range(0, 99) < 40);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
